// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [WORD_WIDTH-1:0]    rf_word_t;

endpackage

// File: rtl/rf_wr_sel.sv
// Priority select over the write ports for one address: highest-index enabled hit wins.
// Purely combinational; address 0 never hits.
module rf_wr_sel
    import rf_pkg::*;
#(
    parameter int N_WR       = 2,
    parameter int ADDR_WIDTH = rf_pkg::RF_ADDR_WIDTH,
    parameter int WORD_WIDTH = rf_pkg::WORD_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [N_WR-1:0]            wr_en,
    input  logic [N_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [N_WR*WORD_WIDTH-1:0] wr_data,
    output logic                       hit,
    output logic [WORD_WIDTH-1:0]      data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (wr_en[i] && (addr != '0) &&
                (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                hit  = 1'b1;
                data = wr_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with write bypass, busy scoreboard and post-reset clear sweep.
// Reads are combinational; writes/reserves land at posedge; no backpressure once ready.
module rf_mp #(
    parameter int WORD_WIDTH = rf_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::RF_ADDR_WIDTH,
    parameter int N_RD       = 2,
    parameter int N_WR       = 2,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [N_RD*ADDR_WIDTH-1:0] rdAddr,
    output logic [N_RD*WORD_WIDTH-1:0] rdData,
    output logic [N_RD-1:0]            rdBusy,
    input  logic [N_WR-1:0]            wrEn,
    input  logic [N_WR*ADDR_WIDTH-1:0] wrAddr,
    input  logic [N_WR*WORD_WIDTH-1:0] wrData,
    input  logic                       rsvEn,
    input  logic [ADDR_WIDTH-1:0]      rsvAddr
);

    import rf_pkg::*;

    localparam int REGS = 2**ADDR_WIDTH;

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [WORD_WIDTH-1:0] regs_q [REGS];
    logic [WORD_WIDTH-1:0] regs_d [REGS];
    logic [REGS-1:0]       busy_q, busy_d;

    logic [REGS-1:0]       wr_hit;
    logic [WORD_WIDTH-1:0] wr_val [REGS];
    logic [N_RD-1:0]       rd_hit;
    logic [WORD_WIDTH-1:0] rd_fwd [N_RD];

    // One selector per array entry resolves multi-port write collisions.
    for (genvar j = 0; j < REGS; j++) begin : g_merge
        rf_wr_sel #(
            .N_WR       (N_WR),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_WIDTH (WORD_WIDTH)
        ) u_merge (
            .addr    (ADDR_WIDTH'(j)),
            .wr_en   (wrEn),
            .wr_addr (wrAddr),
            .wr_data (wrData),
            .hit     (wr_hit[j]),
            .data    (wr_val[j])
        );
    end

    for (genvar r = 0; r < N_RD; r++) begin : g_byp
        rf_wr_sel #(
            .N_WR       (N_WR),
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_WIDTH (WORD_WIDTH)
        ) u_byp (
            .addr    (rdAddr[r*ADDR_WIDTH +: ADDR_WIDTH]),
            .wr_en   (wrEn),
            .wr_addr (wrAddr),
            .wr_data (wrData),
            .hit     (rd_hit[r]),
            .data    (rd_fwd[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array and scoreboard carry no reset; the clear sweep initialises them.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        regs_d    = regs_q;
        busy_d    = busy_q;
        if (state_q == CLEAR) begin
            regs_d[clr_cnt_q] = '0;
            busy_d[clr_cnt_q] = 1'b0;
            clr_cnt_d         = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = RUN;
            end
        end else begin
            for (int j = 0; j < REGS; j++) begin
                if (wr_hit[j]) begin
                    regs_d[j] = wr_val[j];
                    busy_d[j] = 1'b0;
                end
            end
            // Reserve is applied after writes so a same-cycle reserve leaves busy set.
            if (rsvEn && (rsvAddr != '0)) begin
                busy_d[rsvAddr] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] rd_a;
        ready  = (state_q == RUN);
        rdData = '0;
        rdBusy = '0;
        rd_a   = '0;
        for (int r = 0; r < N_RD; r++) begin
            rd_a = rdAddr[r*ADDR_WIDTH +: ADDR_WIDTH];
            if ((state_q == RUN) && (rd_a != '0)) begin
                if ((BYPASS != 0) && rd_hit[r]) begin
                    rdData[r*WORD_WIDTH +: WORD_WIDTH] = rd_fwd[r];
                    rdBusy[r]                          = 1'b0;
                end else begin
                    rdData[r*WORD_WIDTH +: WORD_WIDTH] = regs_q[rd_a];
                    rdBusy[r]                          = busy_q[rd_a];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: bypassing and non-bypassing instances share stimulus and a behavioural model.
module tb_rf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic        ready_b, ready_n;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;

    always #10 clk = ~clk;

    rf_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rdAddr(rd_addr), .rdData(rd_data_b), .rdBusy(rd_busy_b),
        .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rsvEn(rsv_en), .rsvAddr(rsv_addr)
    );

    rf_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n),
        .rdAddr(rd_addr), .rdData(rd_data_n), .rdBusy(rd_busy_n),
        .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rsvEn(rsv_en), .rsvAddr(rsv_addr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: register contents, busy flags, and cycles since reset release.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ready = 1'b0;
    int          m_clr   = 0;

    function automatic void m_exp(input int r, input bit byp,
                                  output logic [31:0] d, output logic b);
        int a;
        a = int'(rd_addr[r*5 +: 5]);
        d = '0;
        b = 1'b0;
        if (!m_ready || a == 0) return;
        d = m_regs[a];
        b = m_busy[a];
        if (byp) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && int'(wr_addr[i*5 +: 5]) == a) begin
                    d = wr_data[i*32 +: 32];
                    b = 1'b0;
                end
            end
        end
    endfunction

    task automatic check_all();
        logic [31:0] d;
        logic        b;
        chk("ready_b", {63'd0, ready_b}, {63'd0, m_ready});
        chk("ready_n", {63'd0, ready_n}, {63'd0, m_ready});
        for (int r = 0; r < 2; r++) begin
            m_exp(r, 1'b1, d, b);
            chk("rd_data_b", {32'd0, rd_data_b[r*32 +: 32]}, {32'd0, d});
            chk("rd_busy_b", {63'd0, rd_busy_b[r]}, {63'd0, b});
            m_exp(r, 1'b0, d, b);
            chk("rd_data_n", {32'd0, rd_data_n[r*32 +: 32]}, {32'd0, d});
            chk("rd_busy_n", {63'd0, rd_busy_n[r]}, {63'd0, b});
        end
    endtask

    task automatic model_tick();
        int a;
        if (rst) begin
            m_ready = 1'b0;
            m_clr   = 0;
        end else if (!m_ready) begin
            m_clr++;
            if (m_clr == 32) begin
                m_ready = 1'b1;
                for (int k = 0; k < 32; k++) begin
                    m_regs[k] = '0;
                    m_busy[k] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                a = int'(wr_addr[i*5 +: 5]);
                if (wr_en[i] && a != 0) begin
                    m_regs[a] = wr_data[i*32 +: 32];
                    m_busy[a] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    // Called at a negedge with inputs set: check before the posedge, then advance the model.
    task automatic cycle();
        #4;
        check_all();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = 5'(a);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rand_inputs(input int amax);
        for (int p = 0; p < 2; p++) begin
            rd_addr[p*5 +: 5]   = 5'($urandom_range(0, amax));
            wr_addr[p*5 +: 5]   = 5'($urandom_range(0, amax));
            wr_data[p*32 +: 32] = $urandom;
        end
        wr_en    = 2'($urandom);
        rsv_en   = 1'($urandom);
        rsv_addr = 5'($urandom_range(0, amax));
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        cnt = 0;
        while (!ready_b && cnt < 100) begin
            rand_inputs(31);
            cycle();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'd32);
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        @(negedge clk);
        repeat (3) cycle();

        // Clear sweep with stray writes/reserves that must be ignored.
        rst = 1'b0;
        count_clear("clr_lat");

        // Reset part-way through a clear restarts the count.
        rst = 1'b1;
        idle();
        cycle();
        rst = 1'b0;
        repeat (10) begin
            rand_inputs(31);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_clear("clr_restart");

        idle();
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            cycle();
        end

        // x5 bypass vs array-only latency.
        set_wr(0, 5, 32'hDEADBEEF);
        rd_addr = {5'd5, 5'd5};
        #2;
        chk("x5_byp", {32'd0, rd_data_b[31:0]}, 64'hDEADBEEF);
        chk("x5_nobyp_old", {32'd0, rd_data_n[63:32]}, 64'h0);
        cycle();
        idle();
        #2;
        chk("x5_nobyp_new", {32'd0, rd_data_n[31:0]}, 64'hDEADBEEF);
        cycle();

        // Two ports hit x7: highest index wins.
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        rd_addr = {5'd7, 5'd7};
        cycle();
        idle();
        #2;
        chk("x7_b", {32'd0, rd_data_b[31:0]}, 64'h22);
        chk("x7_n", {32'd0, rd_data_n[63:32]}, 64'h22);
        cycle();

        // Reserve x3, then write it.
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        rd_addr  = {5'd3, 5'd3};
        cycle();
        idle();
        #2;
        chk("x3_busy", {63'd0, rd_busy_b[0]}, 64'd1);
        cycle();
        set_wr(0, 3, 32'h55);
        #2;
        chk("x3_byp_data", {32'd0, rd_data_b[31:0]}, 64'h55);
        chk("x3_byp_busy", {63'd0, rd_busy_b[1]}, 64'd0);
        chk("x3_arr_busy", {63'd0, rd_busy_n[0]}, 64'd1);
        cycle();
        idle();
        #2;
        chk("x3_after_b", {63'd0, rd_busy_b[0]}, 64'd0);
        chk("x3_after_n", {63'd0, rd_busy_n[1]}, 64'd0);
        cycle();

        // Same-cycle reserve and write to x9: reserve wins busy.
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        set_wr(1, 9, 32'h77);
        cycle();
        idle();
        rd_addr = {5'd9, 5'd9};
        #2;
        chk("x9_data", {32'd0, rd_data_n[31:0]}, 64'h77);
        chk("x9_busy", {62'd0, rd_busy_b}, 64'd3);
        cycle();

        // x0 is hardwired.
        set_wr(0, 0, 32'hFFFFFFFF);
        set_wr(1, 0, 32'hFFFFFFFF);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rd_addr  = '0;
        #2;
        chk("x0_byp", rd_data_b, 64'h0);
        cycle();
        idle();
        #2;
        chk("x0_data", rd_data_n, 64'h0);
        chk("x0_busy", {62'd0, rd_busy_n}, 64'h0);
        cycle();

        // Randomised traffic on a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            rand_inputs((n < 200) ? 7 : 31);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-port register file for the pipelined RV32I core, generalising the single-write/dual-read file. It adds configurable read/write port counts, optional write-to-read bypass, and a per-register busy scoreboard for in-flight producers. A post-reset clear sequencer zeroes the array one entry per cycle, so the file maps to RAM-style storage. It sits in decode: read ports feed operand fetch and hazard detection, and write ports are driven by the writeback lanes.

## Interface
- `WORD_WIDTH`, default `WORD_WIDTH` (32): data width.
- `ADDR_WIDTH`, default `RF_ADDR_WIDTH` (5): address width; `REGS = 2**ADDR_WIDTH`.
- `N_RD`, default 2: read ports.
- `N_WR`, default 2: write ports.
- `BYPASS`, default 1: 1 forwards same-cycle write data to reads; 0 reads array only.

Ports:
- `clk`  in  1  clock; single clock domain, all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `ready`  out  1  high once the clear sequence is complete.
- `rdAddr`  in  N_RD×ADDR_WIDTH  read addresses.
- `rdData`  out  N_RD×WORD_WIDTH  read data (combinational).
- `rdBusy`  out  N_RD  register has a pending producer.
- `wrEn`  in  N_WR  write enables.
- `wrAddr`  in  N_WR×ADDR_WIDTH  write addresses.
- `wrData`  in  N_WR×WORD_WIDTH  write data.
- `rsvEn`  in  1  reserve (mark busy) `rsvAddr`.
- `rsvAddr`  in  ADDR_WIDTH  register being reserved by an issued instruction.

## Operation
- FSM states: `CLEAR`, `RUN`.
  - `rst`=1 forces `CLEAR` and `clrCnt`=0.
  - In `CLEAR`, each cycle with `rst`=0 writes 0 to `regs[clrCnt]`, clears `busy[clrCnt]`, and increments `clrCnt`.
  - After `clrCnt`==REGS-1 is cleared, the FSM moves to `RUN`.
- In `CLEAR`:
  - `ready`=0, all `rdData`=0, all `rdBusy`=0.
  - `wrEn` and `rsvEn` are ignored.
- In `RUN`, `ready`=1.
- Writes: port i with `wrEn[i]` and `wrAddr[i]`≠0 updates `regs[wrAddr[i]]` at the posedge and clears `busy[wrAddr[i]]`.
  - Same address on several ports: the highest-index port wins.
- Reserve: `rsvEn` with `rsvAddr`≠0 sets `busy[rsvAddr]` at the posedge.
  - If the same cycle also has a write to `rsvAddr`, the write lands and the reserve wins, so busy ends at 1.
- Address 0:
  - `rdData`=0 and `rdBusy`=0 always.
  - Writes and reserves to address 0 are dropped.
- Reads (combinational): for port r with `a=rdAddr[r]`:
  - BYPASS=1 and any enabled write port hits `a`≠0: `rdData` = the highest-index hitting port's `wrData`, and `rdBusy`=0.
  - Otherwise `rdData`=`regs[a]` and `rdBusy`=`busy[a]`.
  - The reserve in the same cycle does not affect the reads.
- Reset mid-operation (in `CLEAR` or `RUN`): clear restarts at entry 0. Prior contents are not trusted until `ready`=1.

## Timing
- Reset values: `ready`=0, `rdData`=0, `rdBusy`=0 while `rst`=1 and throughout `CLEAR`.
- Clear latency: `ready` rises exactly REGS cycles after the first posedge sampled with `rst`=0 (32 for defaults).
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: the new value is visible in the cycle after the write posedge.
- Reserve-to-busy latency: 1 cycle. Write-to-busy-clear is also 1 cycle, or 0 on the bypassed read path.
- No stalls or backpressure; every port is accepted every cycle in `RUN`.

## Structure
- Shared package `rf_pkg`:
  - `WORD_WIDTH`, `RF_ADDR_WIDTH` constants.
  - `rf_state_e` {`CLEAR`, `RUN`}.
  - `rf_addr_t` and `rf_word_t` typedefs.
- Sub-module `rf_wr_sel`: per-address priority select over N_WR ports, returning hit and data. It is instantiated once per read port for bypass and reused for the array write-merge.

## Test plan
- Reset, then release: `ready`=0 for 32 cycles and 1 on cycle 32. Every address then reads 0 and not busy. Assert `rst` at cycle 10 and confirm the 32-cycle count restarts.
- Write 0xDEADBEEF to x5 on port 0, reading x5 on both ports the same cycle:
  - BYPASS=1: 0xDEADBEEF immediately.
  - BYPASS=0: old value, then 0xDEADBEEF next cycle.
- Ports 0 and 1 write x7 with 0x11 and 0x22 in the same cycle: reads 0x22 from then on.
- Reserve x3, then `rdBusy`=1 next cycle. Write x3=0x55 and read the same cycle: data 0x55 with busy 0 (BYPASS=1). Busy stays 0 afterwards.
- Same cycle: reserve x9 and write x9=0x77: x9 reads 0x77 with busy 1 next cycle.
- Write 0xFFFFFFFF to x0 and reserve x0: x0 always reads 0 with busy 0. Writes and reserves during `CLEAR` have no effect.
